// File: rtl/mult_div_pkg.sv
// Shared types and constants for the multi-cycle MULT/DIV unit and the control
// unit's mult/div wait states.
package mult_div_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DIV  = 2'd2,
        FIN  = 2'd3
    } state_t;

    // Operation selector, also decoded by the control unit's wait states.
    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

endpackage

// File: rtl/mult_div_unit_div_seq.sv
// Restoring divider core: magnitudes divided one quotient bit per step, signs
// re-applied combinationally on the outputs (truncation toward zero).
module div_seq
    import mult_div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             valid
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs;
    logic             neg_q;
    logic             neg_r;
    logic [CW-1:0]    count;

    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;

    always_comb begin
        abs_a     = dividend[WIDTH-1] ? -dividend : dividend;
        abs_b     = divisor[WIDTH-1] ? -divisor : divisor;
        rem_shift = {rem, quo[WIDTH-1]};
        diff      = rem_shift - {1'b0, dvs};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem   <= '0;
            quo   <= '0;
            dvs   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            count <= '0;
        end else if (load) begin
            rem   <= '0;
            quo   <= abs_a;
            dvs   <= abs_b;
            neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            neg_r <= dividend[WIDTH-1];
            count <= '0;
        end else if (step && !valid) begin
            // A borrow out of the trial subtraction means the divisor did not fit.
            if (diff[WIDTH]) begin
                rem <= rem_shift[WIDTH-1:0];
                quo <= {quo[WIDTH-2:0], 1'b0};
            end else begin
                rem <= diff[WIDTH-1:0];
                quo <= {quo[WIDTH-2:0], 1'b1};
            end
            count <= count + 1'b1;
        end
    end

    // -2^(W-1) / -1 wraps back to -2^(W-1) through the plain negation.
    assign quotient  = neg_q ? -quo : quo;
    assign remainder = neg_r ? -rem : rem;
    assign valid     = (count == CW'(WIDTH));

endmodule

// File: rtl/mult_div_unit.sv
// Signed multi-cycle MULT (radix-2 Booth) / DIV (restoring) unit that owns the
// architectural HI/LO registers.
module mult_div_unit
    import mult_div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mult_start,
    input  logic             div_start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int CW = $clog2(WIDTH);

    state_t             state;
    logic               op_sel;
    logic               dz_pend;
    logic [CW-1:0]      count;
    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH:0]   prod;

    logic [WIDTH:0]     addend;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH:0]   booth_next;

    logic               div_load;
    logic               div_step;
    logic [WIDTH-1:0]   div_quo;
    logic [WIDTH-1:0]   div_rem;
    logic               div_valid;

    // Accumulator add is done one bit wider so the most negative multiplicand
    // cannot overflow; the shifted result always fits back into WIDTH bits.
    always_comb begin
        unique case (prod[1:0])
            2'b01:   addend = {mcand[WIDTH-1], mcand};
            2'b10:   addend = -{mcand[WIDTH-1], mcand};
            default: addend = '0;
        endcase
        sum        = {prod[2*WIDTH], prod[2*WIDTH:WIDTH+1]} + addend;
        booth_next = {sum, prod[WIDTH:1]};
    end

    assign div_load = (state == IDLE) && !mult_start && div_start;
    assign div_step = (state == DIV);

    div_seq #(
        .WIDTH(WIDTH)
    ) u_div_seq (
        .clk      (clk),
        .rst      (rst),
        .load     (div_load),
        .step     (div_step),
        .dividend (op_a),
        .divisor  (op_b),
        .quotient (div_quo),
        .remainder(div_rem),
        .valid    (div_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            op_sel   <= OP_MULT;
            dz_pend  <= 1'b0;
            count    <= '0;
            mcand    <= '0;
            prod     <= '0;
            hi       <= '0;
            lo       <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (mult_start) begin
                        op_sel   <= OP_MULT;
                        mcand    <= op_a;
                        prod     <= {{WIDTH{1'b0}}, op_b, 1'b0};
                        count    <= CW'(WIDTH - 1);
                        busy     <= 1'b1;
                        div_zero <= 1'b0;
                        dz_pend  <= 1'b0;
                        state    <= MULT;
                    end else if (div_start) begin
                        op_sel   <= OP_DIV;
                        count    <= CW'(WIDTH - 1);
                        busy     <= 1'b1;
                        div_zero <= 1'b0;
                        dz_pend  <= (op_b == '0);
                        state    <= (op_b == '0) ? FIN : DIV;
                    end
                end
                MULT: begin
                    prod  <= booth_next;
                    count <= count - 1'b1;
                    if (count == '0) begin
                        state <= FIN;
                    end
                end
                DIV: begin
                    count <= count - 1'b1;
                    if (count == '0) begin
                        state <= FIN;
                    end
                end
                FIN: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                    if (op_sel == OP_MULT) begin
                        hi <= prod[2*WIDTH:WIDTH+1];
                        lo <= prod[WIDTH:1];
                    end else if (dz_pend) begin
                        div_zero <= 1'b1;
                    end else if (div_valid) begin
                        hi <= div_rem;
                        lo <= div_quo;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed-vector bench for mult_div_unit with hand-computed HI/LO and timing.
module tb_mult_div_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         mult_start;
    logic         div_start;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         busy;
    logic         done;
    logic         div_zero;

    int checks   = 0;
    int failures = 0;
    int lat;

    mult_div_unit #(
        .WIDTH(W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mult_start(mult_start),
        .div_start (div_start),
        .op_a      (op_a),
        .op_b      (op_b),
        .hi        (hi),
        .lo        (lo),
        .busy      (busy),
        .done      (done),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues a start at edge 0, scrambles operands afterwards, and returns the
    // number of edges after edge 0 until done is seen (capped at 100).
    task automatic run_op(input logic m, input logic d, input logic [W-1:0] a,
                          input logic [W-1:0] b, output int edges);
        mult_start = m;
        div_start  = d;
        op_a       = a;
        op_b       = b;
        tick();
        mult_start = 1'b0;
        div_start  = 1'b0;
        op_a       = ~a;
        op_b       = ~b;
        edges      = 0;
        while (done !== 1'b1 && edges < 100) begin
            tick();
            edges++;
        end
    endtask

    initial begin
        rst        = 1'b1;
        mult_start = 1'b0;
        div_start  = 1'b0;
        op_a       = '0;
        op_b       = '0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_hi", hi, 32'h0);
        check("rst_lo", lo, 32'h0);
        check("rst_busy", {31'b0, busy}, 32'h0);
        check("rst_done", {31'b0, done}, 32'h0);
        check("rst_dz", {31'b0, div_zero}, 32'h0);

        // 7 * -3 with cycle-exact busy/done
        mult_start = 1'b1;
        op_a       = 32'd7;
        op_b       = 32'hFFFF_FFFD;
        tick();
        mult_start = 1'b0;
        op_a       = '0;
        op_b       = '0;
        check("m1_busy_e0", {31'b0, busy}, 32'h1);
        check("m1_done_e0", {31'b0, done}, 32'h0);
        for (int e = 1; e <= 32; e++) begin
            tick();
            check($sformatf("m1_busy_e%0d", e), {31'b0, busy}, 32'h1);
            check($sformatf("m1_done_e%0d", e), {31'b0, done}, 32'h0);
        end
        tick();
        check("m1_done_e33", {31'b0, done}, 32'h1);
        check("m1_busy_e33", {31'b0, busy}, 32'h0);
        check("m1_hi", hi, 32'hFFFF_FFFF);
        check("m1_lo", lo, 32'hFFFF_FFEB);
        check("m1_dz", {31'b0, div_zero}, 32'h0);
        tick();
        check("m1_done_e34", {31'b0, done}, 32'h0);
        check("m1_hold_hi", hi, 32'hFFFF_FFFF);

        run_op(1'b1, 1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, lat);
        check("m2_lat", lat, 32'd33);
        check("m2_hi", hi, 32'h3FFF_FFFF);
        check("m2_lo", lo, 32'h0000_0001);
        check("m2_dz", {31'b0, div_zero}, 32'h0);
        tick();

        // both starts high: mult wins (6/3 would give lo=2)
        run_op(1'b1, 1'b1, 32'd6, 32'd3, lat);
        check("both_lat", lat, 32'd33);
        check("both_hi", hi, 32'h0);
        check("both_lo", lo, 32'd18);
        tick();

        run_op(1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, lat);
        check("mmin_hi", hi, 32'h4000_0000);
        check("mmin_lo", lo, 32'h0);
        tick();

        run_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, lat);
        check("d1_lat", lat, 32'd33);
        check("d1_lo", lo, 32'hFFFF_FFFD);
        check("d1_hi", hi, 32'hFFFF_FFFF);
        tick();

        run_op(1'b0, 1'b1, 32'd7, 32'hFFFF_FFFE, lat);
        check("d2_lo", lo, 32'hFFFF_FFFD);
        check("d2_hi", hi, 32'h1);
        tick();

        // 0x451 / 0x20 = 0x22 rem 0x11, preloads HI/LO for the divide-by-zero case
        run_op(1'b0, 1'b1, 32'h451, 32'h20, lat);
        check("d3_lo", lo, 32'h22);
        check("d3_hi", hi, 32'h11);
        tick();

        div_start = 1'b1;
        op_a      = 32'd5;
        op_b      = 32'd0;
        tick();
        div_start = 1'b0;
        op_b      = 32'd9;
        check("dz_busy_e0", {31'b0, busy}, 32'h1);
        check("dz_done_e0", {31'b0, done}, 32'h0);
        tick();
        check("dz_done_e1", {31'b0, done}, 32'h1);
        check("dz_flag_e1", {31'b0, div_zero}, 32'h1);
        check("dz_busy_e1", {31'b0, busy}, 32'h0);
        check("dz_hi", hi, 32'h11);
        check("dz_lo", lo, 32'h22);
        tick();
        check("dz_done_e2", {31'b0, done}, 32'h0);
        check("dz_flag_e2", {31'b0, div_zero}, 32'h1);

        run_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat);
        check("dov_lo", lo, 32'h8000_0000);
        check("dov_hi", hi, 32'h0);
        check("dov_dz", {31'b0, div_zero}, 32'h0);
        tick();

        // div_start at edge 5 of a running mult must be ignored
        mult_start = 1'b1;
        op_a       = 32'd3;
        op_b       = 32'd4;
        tick();
        mult_start = 1'b0;
        repeat (4) tick();
        div_start = 1'b1;
        op_a      = 32'd100;
        op_b      = 32'd0;
        tick();
        div_start = 1'b0;
        lat       = 5;
        while (done !== 1'b1 && lat < 100) begin
            tick();
            lat++;
        end
        check("ign_lat", lat, 32'd33);
        check("ign_hi", hi, 32'h0);
        check("ign_lo", lo, 32'd12);
        check("ign_dz", {31'b0, div_zero}, 32'h0);
        tick();

        // reset at edge 10 of a running mult, then mult 2*2 at edge 12
        mult_start = 1'b1;
        op_a       = 32'd5;
        op_b       = 32'd6;
        tick();
        mult_start = 1'b0;
        repeat (9) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_hi", hi, 32'h0);
        check("mrst_lo", lo, 32'h0);
        check("mrst_busy", {31'b0, busy}, 32'h0);
        check("mrst_done", {31'b0, done}, 32'h0);
        tick();
        check("mrst_done_e11", {31'b0, done}, 32'h0);
        check("mrst_busy_e11", {31'b0, busy}, 32'h0);
        run_op(1'b1, 1'b0, 32'd2, 32'd2, lat);
        check("post_lat", lat, 32'd33);
        check("post_lo", lo, 32'd4);
        check("post_hi", hi, 32'h0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Multi-cycle signed MULT/DIV execution unit on the datapath; consumes start strobes from the control unit and writes the architectural HI/LO registers.
- Control unit pulses a start, holds in a wait state while busy=1, and advances on done=1.
- HI/LO are read by the mfhi/mflo path through the MemToReg mux.

Parameters:
- WIDTH, 32, operand/result width; iteration count equals WIDTH.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  synchronous reset, active-high
- mult_start  input  1  one-cycle request: signed op_a*op_b
- div_start  input  1  one-cycle request: signed op_a/op_b
- op_a  input  WIDTH  operand A (from register A)
- op_b  input  WIDTH  operand B (from register B)
- hi  output  WIDTH  HI register (mult upper half / div remainder)
- lo  output  WIDTH  LO register (mult lower half / div quotient)
- busy  output  1  operation in progress
- done  output  1  one-cycle completion pulse
- div_zero  output  1  valid with done; last div had op_b==0

Behaviour:
- Reset: rst sampled high at an edge forces IDLE, hi=0, lo=0, busy=0, done=0, div_zero=0, counter=0. This applies in any state, including mid-operation; the partial result is discarded.
- States: IDLE, MULT, DIV, FIN.
- IDLE:
  - Starts are sampled only in IDLE. Operands are latched at the sampling edge (edge 0).
  - mult_start goes to MULT; div_start goes to DIV. If both are high, MULT wins and div_start is dropped.
  - Starts in any other state are ignored.
- MULT:
  - Radix-2 Booth, one step per cycle, 2*WIDTH+1-bit product register.
  - Counter runs WIDTH-1 down to 0.
  - Leaves to FIN at the edge completing step 0.
- DIV:
  - Restoring division on absolute values, one quotient bit per cycle, WIDTH cycles.
  - Signs are applied on exit: quotient negated if signs differ; remainder takes the sign of op_a (truncation toward zero).
  - op_b==0 at the sampling edge: go to FIN directly with no iterations.
  - -2^(WIDTH-1) / -1 wraps: lo=0x80000000, hi=0, div_zero=0. No trap.
- FIN:
  - On entry edge: hi/lo written (except div-by-zero), done=1 for exactly one cycle, then IDLE.
  - Divide-by-zero: div_zero=1 with done, hi/lo keep their previous values.
- Latency, normal mult/div with WIDTH=32:
  - busy=1 after edge 0 through edge 32.
  - done=1 after edge 33 and busy=0 at the same time; done low after edge 34.
  - A new start can be sampled at edge 34.
- Latency, divide-by-zero: busy=1 after edge 0, done=1 after edge 1.
- Holding and clearing rules:
  - hi/lo hold indefinitely between operations; they change only on FIN entry or rst.
  - div_zero clears on the next accepted start or rst; a mult always completes with div_zero=0.
- busy is a registered output, never combinational from the start inputs.

Decomposition:
- Package mult_div_pkg holds:
  - state enum (IDLE, MULT, DIV, FIN), 2 bits;
  - default WIDTH constant;
  - op-select constants shared with the control unit's mult/div wait states.
- One natural sub-module: div_seq, the restoring divider core with load/step/valid.
  - Owns the remainder/quotient shift registers and the sign fix-up.
  - mult_div_unit keeps the FSM, the Booth multiplier, and HI/LO.

Test Plan:
- mult_start, op_a=7, op_b=0xFFFFFFFD (-3) -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; done high only in the cycle after edge 33; busy high edges 1-32.
- mult_start, op_a=op_b=0x7FFFFFFF -> hi=0x3FFFFFFF, lo=0x00000001, div_zero=0.
- div_start, op_a=0xFFFFFFF9 (-7), op_b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); then op_a=7, op_b=0xFFFFFFFE -> lo=0xFFFFFFFD, hi=1.
- hi=0x11, lo=0x22, then div_start op_a=5, op_b=0 -> done and div_zero high after edge 1; hi=0x11, lo=0x22 unchanged.
- div_start, op_a=0x80000000, op_b=0xFFFFFFFF -> lo=0x80000000, hi=0, div_zero=0.
- Start-while-busy and reset cases:
  - mult 3*4 started, div_start pulsed at edge 5 -> ignored; result hi=0, lo=12.
  - New mult started, rst at edge 10 -> hi=lo=0, busy=0, no done.
  - mult 2*2 at edge 12 -> lo=4 after edge 45.
